// File: rtl/fifo_16to256_if.sv
// Bus bundle for the word-to-burst packing FIFO: 16-bit write side, 256-bit read side.
// Master drives write/read requests; slave (the FIFO) returns data, occupancy and errors.
interface fifo_16to256_if #(
    parameter int DEPTH = 64
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]  data_i;
    logic         data_we;
    logic [3:0]   size_i;
    logic         data_rd;
    logic [255:0] data_o;
    logic [4:0]   avail_o;
    logic [AW:0]  word_cnt;
    logic         full;
    logic         empty;
    logic [1:0]   err;

    modport master (
        output data_i, data_we, size_i, data_rd,
        input  data_o, avail_o, word_cnt, full, empty, err
    );

    modport slave (
        input  data_i, data_we, size_i, data_rd,
        output data_o, avail_o, word_cnt, full, empty, err
    );
endinterface

// File: rtl/fifo_16to256.sv
// Word-to-burst packing FIFO: one 16-bit word in per cycle, up to 16 oldest words
// presented LSB-first on a 256-bit bus, 1..16 words consumed per read.
module fifo_16to256 #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    fifo_16to256_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    logic [15:0]  mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  word_cnt_q;
    logic [1:0]   err_q;

    logic         full_c;
    logic         empty_c;
    logic [4:0]   avail_c;
    logic [4:0]   rd_n;
    logic         wr_acc;
    logic         rd_acc;
    logic [AW:0]  rd_step;
    logic [AW:0]  cnt_next;
    logic [255:0] data_c;

    // Handshake: data_we is honoured only when the pre-edge count is below DEPTH,
    // data_rd only when the requested word count fits in avail_o; a refused request
    // changes no data state and sets its sticky err bit instead.
    always_comb begin
        full_c  = (word_cnt_q == (AW+1)'(DEPTH));
        empty_c = (word_cnt_q == '0);
        avail_c = (word_cnt_q >= (AW+1)'(16)) ? 5'd16 : word_cnt_q[4:0];
        rd_n    = (bus.size_i == 4'd0) ? 5'd16 : {1'b0, bus.size_i};
        wr_acc  = bus.data_we & ~full_c;
        rd_acc  = bus.data_rd & (rd_n <= avail_c);
        rd_step = rd_acc ? (AW+1)'(rd_n) : '0;
        cnt_next = word_cnt_q + {{AW{1'b0}}, wr_acc} - rd_step;
    end

    // Storage carries no reset; lanes beyond avail_o are forced to zero so
    // uninitialised words never reach the outputs.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= bus.data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            word_cnt_q <= '0;
            err_q      <= 2'b00;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            rd_ptr     <= rd_ptr + rd_step;
            word_cnt_q <= cnt_next;
            if (bus.data_we & full_c) begin
                err_q[0] <= 1'b1;
            end
            if (bus.data_rd & ~rd_acc) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    // Lane addresses wrap naturally in AW bits, so a burst crossing the end of
    // memory needs no special handling.
    always_comb begin
        data_c = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < avail_c) begin
                data_c[16*k +: 16] = mem[rd_ptr[AW-1:0] + AW'(k)];
            end
        end
    end

    assign bus.data_o   = data_c;
    assign bus.avail_o  = avail_c;
    assign bus.word_cnt = word_cnt_q;
    assign bus.full     = full_c;
    assign bus.empty    = empty_c;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_fifo_16to256.sv
// Self-checking bench for fifo_16to256: directed scenarios plus random traffic,
// all compared against a queue-based model of the packing FIFO.
module tb_fifo_16to256;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic clk;
    logic reset_n;

    fifo_16to256_if #(.DEPTH(DEPTH)) bus ();

    fifo_16to256 #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [15:0] exp_q[$];
    logic [1:0]  exp_err;
    int          checks;
    int          failures;
    logic [15:0] fill_words[DEPTH];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int model_avail();
        return (exp_q.size() > 16) ? 16 : exp_q.size();
    endfunction

    function automatic logic [255:0] model_data();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < model_avail(); k++) begin
            v[16*k +: 16] = exp_q[k];
        end
        return v;
    endfunction

    task automatic check_state(input string tag);
        check({tag, ".word_cnt"}, 256'(bus.word_cnt), 256'(exp_q.size()));
        check({tag, ".avail"},    256'(bus.avail_o),  256'(model_avail()));
        check({tag, ".full"},     256'(bus.full),     256'(exp_q.size() == DEPTH));
        check({tag, ".empty"},    256'(bus.empty),    256'(exp_q.size() == 0));
        check({tag, ".err"},      256'(bus.err),      256'(exp_err));
        check({tag, ".data"},     bus.data_o,         model_data());
    endtask

    // model of one clock edge, using the occupancy seen before that edge
    task automatic model_step(input logic we, input logic [15:0] d, input logic rd, input logic [3:0] sz);
        int n;
        int av;
        bit can_wr;
        n      = (sz == 4'd0) ? 16 : int'(sz);
        av     = model_avail();
        can_wr = exp_q.size() < DEPTH;
        if (we && !can_wr) exp_err[0] = 1'b1;
        if (rd) begin
            if (n <= av) begin
                repeat (n) void'(exp_q.pop_front());
            end else begin
                exp_err[1] = 1'b1;
            end
        end
        if (we && can_wr) exp_q.push_back(d);
    endtask

    // driver: apply inputs for one cycle, advance the model, check after the edge
    task automatic drive(input string tag, input logic we, input logic [15:0] d,
                         input logic rd, input logic [3:0] sz);
        bus.data_we = we;
        bus.data_i  = d;
        bus.data_rd = rd;
        bus.size_i  = sz;
        @(posedge clk);
        model_step(we, d, rd, sz);
        #1;
        bus.data_we = 1'b0;
        bus.data_rd = 1'b0;
        check_state(tag);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_err = 2'b00;
        check_state(tag);
        reset_n = 1'b1;
        #1;
    endtask

    logic [15:0] ctr;
    logic [15:0] rd_expect;
    logic        rd_now;

    initial begin
        checks   = 0;
        failures = 0;
        exp_err  = 2'b00;
        reset_n  = 1'b0;
        bus.data_i  = '0;
        bus.data_we = 1'b0;
        bus.data_rd = 1'b0;
        bus.size_i  = '0;
        #2;
        check_state("reset0");
        #10;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 20 sequential words
        for (int i = 1; i <= 20; i++) drive("fill20", 1'b1, 16'(i), 1'b0, 4'd0);
        check("t1.cnt",   256'(bus.word_cnt),   256'(20));
        check("t1.avail", 256'(bus.avail_o),    256'(16));
        check("t1.lane0", 256'(bus.data_o[15:0]),    256'(16'h0001));
        check("t1.lane15", 256'(bus.data_o[255:240]), 256'(16'h0010));

        drive("rd16", 1'b0, 16'h0, 1'b1, 4'd0);
        check("t2.cnt",  256'(bus.word_cnt), 256'(4));
        check("t2.data", bus.data_o, {192'h0, 16'h0014, 16'h0013, 16'h0012, 16'h0011});

        drive("rd5", 1'b0, 16'h0, 1'b1, 4'd5);
        check("t3.err", 256'(bus.err), 256'(2'b10));
        check("t3.cnt", 256'(bus.word_cnt), 256'(4));
        drive("rd4", 1'b0, 16'h0, 1'b1, 4'd4);
        check("t3.empty", 256'(bus.empty), 256'(1));
        check("t3.data",  bus.data_o, 256'(0));

        // fill to capacity, then write+read in the full cycle
        do_reset("reset1");
        for (int i = 0; i < DEPTH; i++) begin
            fill_words[i] = 16'($urandom);
            drive("fill64", 1'b1, fill_words[i], 1'b0, 4'd0);
        end
        check("t4.full", 256'(bus.full), 256'(1));
        check("t4.cnt",  256'(bus.word_cnt), 256'(DEPTH));
        drive("full_wr_rd", 1'b1, 16'hDEAD, 1'b1, 4'd1);
        check("t4.err0", 256'(bus.err[0]), 256'(1));
        check("t4.cnt63", 256'(bus.word_cnt), 256'(DEPTH - 1));
        for (int i = 1; i < DEPTH; i++) begin
            check("t4.drain", 256'(bus.data_o[15:0]), 256'(fill_words[i]));
            drive("drain", 1'b0, 16'h0, 1'b1, 4'd1);
        end
        check("t4.empty", 256'(bus.empty), 256'(1));

        // steady stream: one write per cycle, read 3 every third cycle
        do_reset("reset2");
        ctr       = 16'h0100;
        rd_expect = 16'h0100;
        for (int c = 0; c < 500; c++) begin
            rd_now = (c % 3 == 2) && (model_avail() >= 3);
            if (rd_now) begin
                for (int k = 0; k < 3; k++) begin
                    check("stress.seq", 256'(bus.data_o[16*k +: 16]), 256'(rd_expect + 16'(k)));
                end
                rd_expect = rd_expect + 16'd3;
            end
            drive("stress", 1'b1, ctr, rd_now, 4'd3);
            ctr = ctr + 16'd1;
        end
        check("stress.err", 256'(bus.err), 256'(0));

        // random traffic
        for (int c = 0; c < 400; c++) begin
            drive("random", 1'($urandom_range(0, 1)), 16'($urandom),
                  ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end

        // asynchronous reset while holding data
        do_reset("reset3");
        for (int i = 0; i < 10; i++) drive("hold10", 1'b1, 16'(16'h0A00 + i), 1'b0, 4'd0);
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        exp_err = 2'b00;
        check("t6.cnt",   256'(bus.word_cnt), 256'(0));
        check("t6.empty", 256'(bus.empty),    256'(1));
        check("t6.avail", 256'(bus.avail_o),  256'(0));
        check("t6.data",  bus.data_o,         256'(0));
        check("t6.err",   256'(bus.err),      256'(0));
        #1;
        reset_n = 1'b1;
        drive("post_reset_wr", 1'b1, 16'hBEEF, 1'b0, 4'd0);
        check("t6.lane0", 256'(bus.data_o[15:0]), 256'(16'hBEEF));
        check("t6.cnt1",  256'(bus.word_cnt),     256'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
